fetch_pc_unit: RTL and testbench
================================

# fetch_pc_unit

Fetch-side owner of the program counter: holds the architectural PC and sequences instruction-memory reads through a request/done handshake. Presents the fetched instruction to decode and drives `pc_plus2` and `epcValue` to the next-PC adder. Consumes the adder's `nextpc` when an instruction retires with a redirect. Also owns the EPC register written on SIIC entry.

## Interface
Parameters:
- `RESET_PC`, 16'h0000, PC loaded on reset
- `NOP_INSTR`, 16'h0800, value driven on `instr` when no valid instruction is held

Ports:
- `clk`  in  1  system clock, all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `nextpc`  in  16  target from next-PC adder
- `take_nextpc`  in  1  retiring instruction redirects to `nextpc`
- `stall`  in  1  decode cannot accept `instr` this cycle
- `halt`  in  1  retiring instruction is HALT
- `epc_wr`  in  1  load EPC this cycle
- `epc_wr_data`  in  16  EPC value (pc+2 of SIIC instruction)
- `imem_req`  out  1  one-cycle read request
- `imem_addr`  out  16  read address (= PC)
- `imem_done`  in  1  read data valid
- `imem_data`  in  16  instruction word
- `instr`  out  16  held instruction
- `instr_valid`  out  1  `instr` valid for decode
- `pc_plus2`  out  16  PC + 2 of held instruction
- `epcValue`  out  16  EPC register
- `halted`  out  1  fetch stopped (HALT or error)
- `err`  out  1  sticky misaligned-redirect error

## Operation
- States: `S_REQ`, `S_WAIT`, `S_VALID`, `S_HALT`.
- `S_REQ`: `imem_req`=1, `imem_addr`=PC; next state `S_WAIT`. `imem_done` ignored in this state.
- `S_WAIT`: `imem_req`=0. On `imem_done`, latch `imem_data` into `instr` and go to `S_VALID`; otherwise stay.
- `S_VALID`: `instr_valid`=1. Retire condition is `!stall`; while `stall`=1, hold `instr` and PC.
- At retire, with priority: `halt` → `S_HALT`; else if `take_nextpc`, PC←`nextpc`; else PC←PC+2. Then go to `S_REQ`.
- `take_nextpc`, `halt` and `nextpc` are sampled only in the retire cycle and ignored otherwise.
- `S_HALT`: `halted`=1, `imem_req`=0, `instr_valid`=0. Exit only via `rst`.
- `pc_plus2` = PC + 2, combinational from the PC register, modulo 2^16 (0xFFFE+2 → 0x0000, no flag).
- EPC: `epc_wr`=1 → EPC←`epc_wr_data` next edge, in any state including `S_HALT`. `epcValue` = EPC register.
- `instr` = `NOP_INSTR` in every state other than `S_VALID`.
- Reset values: PC=`RESET_PC`, state `S_REQ`, EPC=0, `err`=0, `halted`=0, `instr_valid`=0, `instr`=`NOP_INSTR`, `imem_req`=0 during the reset cycle.

## Timing
- First `imem_req` asserts in the first cycle after `rst` deasserts.
- Best case, request to `instr_valid` is 2 cycles (done one cycle after req); each added wait cycle adds 1.
- Back-to-back instructions with no stall: one instruction per (memory latency + 2) cycles.
- `imem_done` arriving outside `S_WAIT` is ignored. Memory never returns done in the req cycle.
- `rst` mid-fetch (in `S_WAIT`) abandons the read; a late `imem_done` after reset is ignored because the FSM is in `S_REQ`.
- If `epc_wr` and retire occur in the same cycle, both take effect independently.

## Configuration
- `FETCH_ALIGN_CHECK_EN` defined: a retire with `take_nextpc`=1 and `nextpc[0]`=1 sets `err`=1 (sticky until `rst`), enters `S_HALT`, and leaves PC unchanged.
- `FETCH_ALIGN_CHECK_EN` undefined: `err` is tied 0; the redirect loads `nextpc` with bit 0 forced to 0.

## Structure
- Shared package/header holds: state encodings, `NOP_INSTR` default, 16-bit word-width constant.
- One sub-module: `pc_reg`, a 16-bit register with synchronous reset value, write enable, and parallel load. Instantiated for both PC and EPC.
- PC+2 uses the existing 16-bit ripple-carry adder.

## Test plan
- Reset, memory done 1 cycle after req, no stall: `imem_addr` sequence 0x0000, 0x0002, 0x0004; `instr_valid` every 3rd cycle.
- `stall` high 4 cycles in `S_VALID`: `instr` and `pc_plus2` constant; no `imem_req`; PC advances only after stall drops.
- Retire with `take_nextpc`=1, `nextpc`=0x1234: next `imem_addr`=0x1234, `pc_plus2`=0x1236 once valid.
- `halt` at retire: `halted`=1 next cycle; no further `imem_req` for 20 cycles; `epc_wr` still updates `epcValue`.
- PC=0xFFFE, sequential retire: next `imem_addr`=0x0000, no error.
- With `FETCH_ALIGN_CHECK_EN`, redirect to 0x0101: `err`=1, `halted`=1, PC held. Without it: fetch from 0x0100.

Source files
------------

// File: rtl/fetch_pc_unit_pkg.sv
// Shared types and constants for the fetch PC unit.
// State encodings, word width, default NOP and the PC adder.
package fetch_pc_unit_pkg;

  localparam int WORD_W = 16;
  localparam logic [WORD_W-1:0] NOP_DEFAULT = 16'h0800;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_VALID = 2'd2,
    S_HALT  = 2'd3
  } fetch_state_t;

  // 16-bit ripple-carry adder used for the sequential PC.
  function automatic logic [WORD_W-1:0] rca16(
    input logic [WORD_W-1:0] a,
    input logic [WORD_W-1:0] b
  );
    logic [WORD_W-1:0] s;
    logic              c;
    c = 1'b0;
    for (int i = 0; i < WORD_W; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    return s;
  endfunction

endpackage

// File: rtl/fetch_pc_unit_pc_reg.sv
// Word register with synchronous reset value and load enable.
// Used for both the PC and the EPC.
module pc_reg
  import fetch_pc_unit_pkg::*;
#(
  parameter logic [WORD_W-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [WORD_W-1:0] d,
  output logic [WORD_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst)
      q <= RST_VAL;
    else if (we)
      q <= d;
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch-side PC owner: sequences imem reads, holds instr and EPC.
// Define FETCH_ALIGN_CHECK_EN to trap odd redirect targets.
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC  = 16'h0000,
  parameter logic [WORD_W-1:0] NOP_INSTR = NOP_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] nextpc,
  input  logic              take_nextpc,
  input  logic              stall,
  input  logic              halt,
  input  logic              epc_wr,
  input  logic [WORD_W-1:0] epc_wr_data,
  output logic              imem_req,
  output logic [WORD_W-1:0] imem_addr,
  input  logic              imem_done,
  input  logic [WORD_W-1:0] imem_data,
  output logic [WORD_W-1:0] instr,
  output logic              instr_valid,
  output logic [WORD_W-1:0] pc_plus2,
  output logic [WORD_W-1:0] epcValue,
  output logic              halted,
  output logic              err
);

  fetch_state_t      state_q;
  fetch_state_t      state_d;
  logic [WORD_W-1:0] pc_q;
  logic [WORD_W-1:0] pc_d;
  logic [WORD_W-1:0] instr_q;
  logic [WORD_W-1:0] redirect_pc;
  logic              retire;
  logic              misalign;
  logic              pc_we;

  assign retire = (state_q == S_VALID) && !stall;

`ifdef FETCH_ALIGN_CHECK_EN
  logic err_q;

  assign misalign    = take_nextpc & nextpc[0];
  assign redirect_pc = nextpc;
  assign err         = err_q;

  always_ff @(posedge clk) begin
    if (rst)
      err_q <= 1'b0;
    else if (retire && !halt && misalign)
      err_q <= 1'b1;
  end
`else
  assign misalign    = 1'b0;
  assign redirect_pc = nextpc & ~16'h0001;
  assign err         = 1'b0;
`endif

  assign pc_plus2  = rca16(pc_q, 16'd2);
  assign imem_addr = pc_q;
  assign pc_we     = retire && !halt && !misalign;
  assign pc_d      = take_nextpc ? redirect_pc : pc_plus2;

  pc_reg #(.RST_VAL(RESET_PC)) u_pc (
    .clk (clk),
    .rst (rst),
    .we  (pc_we),
    .d   (pc_d),
    .q   (pc_q)
  );

  pc_reg #(.RST_VAL('0)) u_epc (
    .clk (clk),
    .rst (rst),
    .we  (epc_wr),
    .d   (epc_wr_data),
    .q   (epcValue)
  );

  always_ff @(posedge clk) begin
    if (rst)
      state_q <= S_REQ;
    else
      state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst)
      instr_q <= NOP_INSTR;
    else if (state_q == S_WAIT && imem_done)
      instr_q <= imem_data;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_REQ:   state_d = S_WAIT;
      S_WAIT:  if (imem_done) state_d = S_VALID;
      S_VALID: begin
        if (retire)
          state_d = (halt || misalign) ? S_HALT : S_REQ;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_REQ;
    endcase
  end

  // Outputs are forced idle while reset is held.
  always_comb begin
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    halted      = 1'b0;
    instr       = NOP_INSTR;
    if (!rst) begin
      unique case (state_q)
        S_REQ:   imem_req = 1'b1;
        S_VALID: begin
          instr_valid = 1'b1;
          instr       = instr_q;
        end
        S_HALT:  halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit with a memory model
// and an instruction scoreboard.
module tb_fetch_pc_unit;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc2;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] nextpc = '0;
  logic        take_nextpc = 1'b0;
  logic        stall = 1'b0;
  logic        halt = 1'b0;
  logic        epc_wr = 1'b0;
  logic [15:0] epc_wr_data = '0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_done = 1'b0;
  logic [15:0] imem_data = '0;
  logic [15:0] instr;
  logic        instr_valid;
  logic [15:0] pc_plus2;
  logic [15:0] epcValue;
  logic        halted;
  logic        err;

  int   passed = 0;
  int   total = 0;
  int   lat = 1;
  int   cnt = 0;
  logic [15:0] ma = '0;
  logic prev_valid = 1'b0;
  exp_t sb[$];

  fetch_pc_unit dut (
    .clk         (clk),
    .rst         (rst),
    .nextpc      (nextpc),
    .take_nextpc (take_nextpc),
    .stall       (stall),
    .halt        (halt),
    .epc_wr      (epc_wr),
    .epc_wr_data (epc_wr_data),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_done   (imem_done),
    .imem_data   (imem_data),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc_plus2    (pc_plus2),
    .epcValue    (epcValue),
    .halted      (halted),
    .err         (err)
  );

  always #5 clk = ~clk;

  // Memory model plus scoreboard: push on request, pop on new valid.
  always @(negedge clk) begin
    exp_t e;
    #2;
    imem_done = 1'b0;
    if (rst) begin
      sb.delete();
      cnt = 0;
      prev_valid = 1'b0;
    end else begin
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          imem_done = 1'b1;
          imem_data = ma ^ 16'h5A5A;
        end
      end
      if (imem_req) begin
        cnt = lat;
        ma  = imem_addr;
        sb.push_back('{ma ^ 16'h5A5A, ma + 16'd2});
      end
      if (instr_valid && !prev_valid) begin
        total++;
        if (sb.size() == 0) begin
          $display("FAIL sb_empty: instr %h with nothing expected", instr);
        end else begin
          e = sb.pop_front();
          if (instr !== e.instr || pc_plus2 !== e.pc2)
            $display("FAIL sb_instr: got %h/%h want %h/%h",
                     instr, pc_plus2, e.instr, e.pc2);
          else
            passed++;
        end
      end
      prev_valid = instr_valid;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (instr_valid) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    total++;
    if ({imem_req, instr_valid, halted, err} !== 4'b0000)
      $display("FAIL rst_ctl: got %b want 0000",
               {imem_req, instr_valid, halted, err});
    else passed++;
    total++;
    if (instr !== 16'h0800)
      $display("FAIL rst_instr: got %h want 0800", instr);
    else passed++;
    total++;
    if (epcValue !== 16'h0000 || pc_plus2 !== 16'h0002)
      $display("FAIL rst_regs: got %h/%h want 0000/0002",
               epcValue, pc_plus2);
    else passed++;
    rst = 1'b0;
    #1;
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0000)
      $display("FAIL rst_first_req: got %b/%h want 1/0000",
               imem_req, imem_addr);
    else passed++;
  endtask

  task automatic test_sequential();
    logic [15:0] addrs[$];
    int          vc[$];
    logic        pv;
    pv = 1'b0;
    lat = 1;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      if (imem_req) addrs.push_back(imem_addr);
      if (instr_valid && !pv) vc.push_back(i);
      pv = instr_valid;
      if (vc.size() == 3) break;
      step();
    end
    total++;
    if (vc.size() != 3 || addrs.size() < 3) begin
      $display("FAIL seq_timeout: got %0d valids want 3", vc.size());
    end else begin
      passed++;
      for (int k = 0; k < 3; k++) begin
        total++;
        if (addrs[k] !== 16'(2 * k))
          $display("FAIL seq_addr%0d: got %h want %h",
                   k, addrs[k], 16'(2 * k));
        else passed++;
      end
      for (int k = 1; k < 3; k++) begin
        total++;
        if (vc[k] - vc[k-1] != 3)
          $display("FAIL seq_gap%0d: got %0d want 3",
                   k, vc[k] - vc[k-1]);
        else passed++;
      end
    end
  endtask

  task automatic test_stall();
    bit          ok;
    logic [15:0] i0;
    logic [15:0] p0;
    wait_valid(ok);
    total++;
    if (!ok) $display("FAIL stall_wait: got no valid want valid");
    else passed++;
    stall = 1'b1;
    i0 = instr;
    p0 = pc_plus2;
    for (int k = 0; k < 4; k++) begin
      step();
      total++;
      if (instr !== i0 || pc_plus2 !== p0 || imem_req !== 1'b0
          || instr_valid !== 1'b1)
        $display("FAIL stall_hold%0d: got %h/%h/%b want %h/%h/0",
                 k, instr, pc_plus2, imem_req, i0, p0);
      else passed++;
    end
    stall = 1'b0;
    step();
    total++;
    if (imem_req !== 1'b1 || imem_addr !== p0)
      $display("FAIL stall_advance: got %b/%h want 1/%h",
               imem_req, imem_addr, p0);
    else passed++;
  endtask

  task automatic test_redirect();
    bit ok;
    wait_valid(ok);
    take_nextpc = 1'b1;
    nextpc = 16'h1234;
    epc_wr = 1'b1;
    epc_wr_data = 16'h0042;
    step();
    take_nextpc = 1'b0;
    nextpc = 16'hDEAD;
    epc_wr = 1'b0;
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h1234)
      $display("FAIL redir_addr: got %b/%h want 1/1234",
               imem_req, imem_addr);
    else passed++;
    total++;
    if (epcValue !== 16'h0042)
      $display("FAIL redir_epc: got %h want 0042", epcValue);
    else passed++;
    wait_valid(ok);
    total++;
    if (!ok || pc_plus2 !== 16'h1236)
      $display("FAIL redir_pc2: got %h want 1236", pc_plus2);
    else passed++;
  endtask

  task automatic test_wrap();
    bit ok;
    wait_valid(ok);
    take_nextpc = 1'b1;
    nextpc = 16'hFFFE;
    step();
    take_nextpc = 1'b0;
    wait_valid(ok);
    total++;
    if (!ok || pc_plus2 !== 16'h0000)
      $display("FAIL wrap_pc2: got %h want 0000", pc_plus2);
    else passed++;
    step();
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0000 || err !== 1'b0)
      $display("FAIL wrap_addr: got %b/%h/%b want 1/0000/0",
               imem_req, imem_addr, err);
    else passed++;
  endtask

  task automatic test_misalign();
    bit          ok;
    logic [15:0] p0;
    wait_valid(ok);
    p0 = pc_plus2;
    take_nextpc = 1'b1;
    nextpc = 16'h0101;
    step();
    take_nextpc = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    total++;
    if (err !== 1'b1 || halted !== 1'b1 || imem_req !== 1'b0
        || pc_plus2 !== p0)
      $display("FAIL misalign_trap: got %b/%b/%b/%h want 1/1/0/%h",
               err, halted, imem_req, pc_plus2, p0);
    else passed++;
`else
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0100 || err !== 1'b0
        || p0 === 16'h0102)
      $display("FAIL misalign_mask: got %b/%h/%b want 1/0100/0",
               imem_req, imem_addr, err);
    else passed++;
`endif
    do_reset();
  endtask

  task automatic test_halt();
    bit ok;
    int reqs;
    reqs = 0;
    wait_valid(ok);
    halt = 1'b1;
    step();
    halt = 1'b0;
    total++;
    if (halted !== 1'b1 || instr_valid !== 1'b0 || instr !== 16'h0800)
      $display("FAIL halt_enter: got %b/%b/%h want 1/0/0800",
               halted, instr_valid, instr);
    else passed++;
    for (int k = 0; k < 20; k++) begin
      if (imem_req) reqs++;
      step();
    end
    total++;
    if (reqs != 0 || halted !== 1'b1)
      $display("FAIL halt_noreq: got %0d reqs want 0", reqs);
    else passed++;
    epc_wr = 1'b1;
    epc_wr_data = 16'hBEEF;
    step();
    epc_wr = 1'b0;
    total++;
    if (epcValue !== 16'hBEEF)
      $display("FAIL halt_epc: got %h want beef", epcValue);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int n;
    bit ok;
    lat = 3;
    do_reset();
    n = 0;
    while (!instr_valid && n < 20) begin
      step();
      n++;
    end
    total++;
    if (n != 4)
      $display("FAIL lat3_valid: got %0d cycles want 4", n);
    else passed++;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0000)
      $display("FAIL midfetch_rst: got %b/%h want 1/0000",
               imem_req, imem_addr);
    else passed++;
    wait_valid(ok);
    total++;
    if (!ok || pc_plus2 !== 16'h0002)
      $display("FAIL midfetch_pc2: got %h want 0002", pc_plus2);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_wrap();
    test_misalign();
    test_halt();
    test_back_to_back();
    step();
    step();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
